// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the instruction and data ports in front of the shared multi-cycle memory.
// Every access is followed by one enable-low CLEAR cycle, which flushes the memory read pipeline.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [15:0]           i_wdata,
  output logic                  i_done,
  output logic                  i_err,
  output logic [15:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic [15:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, CLEAR} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    lat_d, lat_wr, err_q, prio_d;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [15:0]             lat_wdata;

  logic                    grant_any, grant_d, sel_wr, timeout_hit;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [15:0]             sel_wdata;

  // prio_d = 1 means the data port wins a simultaneous request
  always_comb begin
    grant_any   = i_req | d_req;
    grant_d     = d_req & (~i_req | prio_d);
    sel_wr      = grant_d ? d_wr    : i_wr;
    sel_addr    = grant_d ? d_addr  : i_addr;
    sel_wdata   = grant_d ? d_wdata : i_wdata;
    timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          if (sel_addr[0])  state_nxt = CLEAR;
          else if (sel_wr)  state_nxt = WRITE;
          else              state_nxt = READ;
        end
      end
      READ:    if (mem_valid || timeout_hit) state_nxt = CLEAR;
      WRITE:   state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_d     <= 1'b0;
      lat_wr    <= 1'b0;
      err_q     <= 1'b0;
      prio_d    <= 1'b1;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            lat_d     <= grant_d;
            lat_wr    <= sel_wr;
            lat_addr  <= {sel_addr[ADDR_WIDTH-1:1], 1'b0};
            lat_wdata <= sel_wdata;
            prio_d    <= ~grant_d;
            err_q     <= sel_addr[0];
            cnt       <= '0;
          end
        end
        READ: begin
          cnt <= cnt + 1'b1;
          if (mem_valid) begin
            err_q <= 1'b0;
            if (lat_d) d_rdata <= mem_rdata;
            else       i_rdata <= mem_rdata;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // memory strobes and completion flags decode straight off the state register
  assign mem_en    = (state == READ) | (state == WRITE);
  assign mem_wr    = (state == WRITE) & lat_wr;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);
  assign i_done    = (state == CLEAR) & ~lat_d;
  assign d_done    = (state == CLEAR) &  lat_d;
  assign i_err     = i_done & err_q;
  assign d_err     = d_done & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction table plus hand sequences for
// simultaneous requests and reset in the middle of a read, against a 4-cycle memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_done, i_err, d_done, d_err;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_en, mem_wr, mem_valid, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy)
  );

  // memory model: valid four cycles after the first enabled read cycle, pipeline flushed by en=0
  logic [15:0] mem [0:127];
  logic [3:0]  pipe;
  logic        mem_init, stuck;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 128; j++) mem[j] <= 16'h0000;
      mem[8] <= 16'hBEEF;
      pipe   <= 4'b0000;
    end else begin
      if (mem_en && mem_wr) mem[mem_addr[7:1]] <= mem_wdata;
      if (mem_en && !mem_wr) pipe <= {pipe[2:0], 1'b1};
      else                   pipe <= 4'b0000;
    end
  end

  assign mem_valid = pipe[3] & ~stuck;
  assign mem_rdata = mem[mem_addr[7:1]];

  typedef struct {
    logic        port_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        stuck;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {25'd0, i_done, d_done, i_err, d_err, mem_en, mem_wr, busy}, 32'd0);
    check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check({tag, "_i_rdata"}, {16'd0, i_rdata}, 32'd0);
    check({tag, "_d_rdata"}, {16'd0, d_rdata}, 32'd0);
  endtask

  // Call at a negedge while the DUT is idle; returns at a negedge in the following idle cycle.
  task automatic run_vec(input string tag, input vec_t v);
    int          lat = 0;
    int          en_cnt = 0;
    logic        other_done = 1'b0;
    logic        seen_en = 1'b0;
    logic        err_at_done = 1'b0;
    logic        en_at_done = 1'b1;
    logic [15:0] other_before;
    logic [15:0] rdata_at_done = 16'h0;
    stuck = v.stuck;
    other_before = v.port_d ? i_rdata : d_rdata;
    if (v.port_d) begin
      d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      i_wr = v.wr; i_addr = v.addr; i_wdata = v.wdata; i_req = 1'b1;
    end
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (!seen_en) begin
          seen_en = 1'b1;
          check({tag, "_mem_addr"}, {16'd0, mem_addr}, {16'd0, v.addr & 16'hFFFE});
          check({tag, "_mem_wr"}, {31'd0, mem_wr}, {31'd0, v.wr});
          if (v.wr) check({tag, "_mem_wdata"}, {16'd0, mem_wdata}, {16'd0, v.wdata});
        end
      end
      if (v.port_d ? i_done : d_done) other_done = 1'b1;
      if (v.port_d ? d_done : i_done) begin
        lat           = n;
        err_at_done   = v.port_d ? d_err : i_err;
        rdata_at_done = v.port_d ? d_rdata : i_rdata;
        en_at_done    = mem_en;
        break;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_err"}, {31'd0, err_at_done}, {31'd0, v.exp_err});
    check({tag, "_rdata"}, {16'd0, rdata_at_done}, {16'd0, v.exp_rdata});
    check({tag, "_en_cycles"}, en_cnt, v.exp_en);
    check({tag, "_en_low_at_done"}, {31'd0, en_at_done}, 32'd0);
    check({tag, "_other_done"}, {31'd0, other_done}, 32'd0);
    check({tag, "_other_rdata"}, {16'd0, v.port_d ? i_rdata : d_rdata}, {16'd0, other_before});
    stuck = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   got;
    int   done_t [4];
    logic done_p [4];
    logic both;
    logic extra_done;
    vec_t v;

    //          port wr  addr      wdata     stk err rdata     lat en
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 6, 5};
    vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0000, 2, 1};
    vecs[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h1234, 6, 5};
    vecs[3] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1, 0};
    vecs[4] = '{1'b1, 1'b1, 16'h0040, 16'hA5A5, 1'b0, 1'b0, 16'hBEEF, 2, 1};
    vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 6, 5};
    vecs[6] = '{1'b0, 1'b0, 16'h0021, 16'h0000, 1'b0, 1'b1, 16'h1234, 1, 0};
    vecs[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 9, 8};
    vecs[8] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 6, 5};

    rst = 1'b1; mem_init = 1'b1; stuck = 1'b0;
    i_req = 1'b0; i_wr = 1'b0; i_addr = 16'h0; i_wdata = 16'h0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mem_init = 1'b0;
    @(posedge clk);
    @(negedge clk);

    for (int k = 0; k < 9; k++) run_vec($sformatf("v%0d", k), vecs[k]);

    // both ports requesting reads continuously from reset: d, i, d, i every 7 cycles
    rst = 1'b1;
    i_wr = 1'b0; i_addr = 16'h0020; i_req = 1'b1;
    d_wr = 1'b0; d_addr = 16'h0010; d_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    both = 1'b0;
    for (int j = 0; j < 4; j++) begin done_t[j] = 0; done_p[j] = 1'b0; end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (i_done && d_done) both = 1'b1;
      if (i_done || d_done) begin
        done_t[got] = n;
        done_p[got] = d_done;
        if (d_done) check($sformatf("rr%0d_d_rdata", got), {16'd0, d_rdata}, 32'h0000BEEF);
        else        check($sformatf("rr%0d_i_rdata", got), {16'd0, i_rdata}, 32'h00001234);
        got++;
        if (got == 4) break;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    check("rr_count", got, 4);
    check("rr_both_done", {31'd0, both}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr%0d_port", j), {31'd0, done_p[j]}, {31'd0, (j % 2 == 0)});
      check($sformatf("rr%0d_time", j), done_t[j], 6 + 7 * j);
    end
    @(posedge clk);
    @(negedge clk);

    // reset asserted in the third READ cycle of a data read
    d_wr = 1'b0; d_addr = 16'h0040; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    check("rst_mid_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    extra_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (i_done || d_done) extra_done = 1'b1;
    end
    check("rst_mid_no_done", {31'd0, extra_done}, 32'd0);
    v = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 6, 5};
    run_vec("post_rst", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
